// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: the CPU port and a DMA master share one
// single-ported memory. Transfers are serialised, contention is resolved
// round-robin, and a watchdog aborts transfers the memory never acknowledges.
//
// state | meaning
// IDLE  | no transfer; pick a requester, latch its request
// XFER  | memory strobe held, waiting for mem_ready or watchdog expiry
// DONE  | one-cycle ready pulse (and data/abort status) to the owner
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          ExternalReset_n,
  input  logic          cpu_ReadMem,
  input  logic          cpu_WriteMem,
  input  logic [AW-1:0] cpu_Addressbus,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_Databus,
  output logic          cpu_MemDataready,
  input  logic          dma_rd,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          cpu_gnt,
  output logic          dma_gnt,
  output logic          timeout_err
);

  // A disabled watchdog still needs a one-bit counter to keep the code legal.
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state;
  logic          last_dma;
  logic          own_dma;
  logic [WW-1:0] wd_cnt;

  logic          cpu_act;
  logic          dma_act;
  logic          pick_dma;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_wr;
  logic [WW-1:0] wd_next;
  logic          wd_hit;
  logic [DW-1:0] ret_data;

  // Round-robin choice, selected request fields and watchdog compare.
  always_comb begin
    cpu_act   = cpu_ReadMem | cpu_WriteMem;
    dma_act   = dma_rd | dma_wr;
    // DMA wins when it is alone, or when both ask and the CPU went last.
    pick_dma  = dma_act && (!cpu_act || !last_dma);
    sel_addr  = pick_dma ? dma_addr  : cpu_Addressbus;
    sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
    // Write takes priority when a requester raises rd and wr together.
    sel_wr    = pick_dma ? dma_wr    : cpu_WriteMem;
    wd_next   = (wd_cnt == '1) ? wd_cnt : wd_cnt + WW'(1);
    wd_hit    = (TIMEOUT != 0) && (wd_next == WW'(TIMEOUT));
    ret_data  = mem_ready ? mem_rdata : '1;
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge ExternalReset_n) begin
    if (!ExternalReset_n) begin
      state            <= IDLE;
      last_dma         <= 1'b1;
      own_dma          <= 1'b0;
      wd_cnt           <= '0;
      cpu_Databus      <= '0;
      cpu_MemDataready <= 1'b0;
      dma_rdata        <= '0;
      dma_ready        <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      cpu_gnt          <= 1'b0;
      dma_gnt          <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_act || dma_act) begin
            own_dma   <= pick_dma;
            last_dma  <= pick_dma;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_write <= sel_wr;
            mem_read  <= !sel_wr;
            cpu_gnt   <= !pick_dma;
            dma_gnt   <= pick_dma;
            wd_cnt    <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          // An acknowledge in the same cycle as expiry still counts as success.
          if (mem_ready || wd_hit) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            timeout_err <= !mem_ready;
            if (own_dma) dma_ready        <= 1'b1;
            else         cpu_MemDataready <= 1'b1;
            // mem_write still holds the direction of this transfer.
            if (!mem_write) begin
              if (own_dma) dma_rdata   <= ret_data;
              else         cpu_Databus <= ret_data;
            end
            state <= DONE;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        DONE: begin
          cpu_MemDataready <= 1'b0;
          dma_ready        <= 1'b0;
          timeout_err      <= 1'b0;
          cpu_gnt          <= 1'b0;
          dma_gnt          <= 1'b0;
          wd_cnt           <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        ExternalReset_n;
  logic        cpu_ReadMem, cpu_WriteMem;
  logic [15:0] cpu_Addressbus, cpu_wdata, cpu_Databus;
  logic        cpu_MemDataready;
  logic        dma_rd, dma_wr;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ready;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        cpu_gnt, dma_gnt, timeout_err;

  mem_port_arbiter #(.AW(16), .DW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .ExternalReset_n(ExternalReset_n),
    .cpu_ReadMem(cpu_ReadMem), .cpu_WriteMem(cpu_WriteMem),
    .cpu_Addressbus(cpu_Addressbus), .cpu_wdata(cpu_wdata),
    .cpu_Databus(cpu_Databus), .cpu_MemDataready(cpu_MemDataready),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // One observed transfer: strobe phase plus the ready cycle that closed it.
  typedef struct {
    int          owner;
    int          start;
    int          done_c;
    int          len;
    int          waits;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        stable;
    logic [1:0]  rdy;
    logic        terr;
    logic [15:0] cpu_d;
    logic [15:0] dma_d;
    logic        act_cpu;
    logic        act_dma;
    logic        c_wr;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
  } xrec_t;

  typedef struct {
    bit          dma;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] rdata;
    int          exp_len;
    bit          exp_to;
    logic [15:0] exp_d;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          strobe_cycles = 0;
  bit          in_xfer = 0;
  bit          have_xfer = 0;
  xrec_t       cur;
  xrec_t       recs[$];
  bit          rand_mode = 0;
  bit          gen_en = 0;
  bit          idle_noise = 0;
  int          resp_waits = 0;
  logic [15:0] resp_rdata = 16'h0000;
  bit          cpu_auto = 1;
  bit          dma_auto = 1;
  int          cpu_gap = 0;
  int          dma_gap = 0;
  logic [15:0] rmem[8];
  logic [15:0] ref_mem[8];
  logic [15:0] exp_cpu_d = 16'h0000;
  logic [15:0] exp_dma_d = 16'h0000;
  bit          model_last_dma = 1;
  int          nrand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int gnt_owner();
    if (cpu_gnt && !dma_gnt) return 0;
    if (dma_gnt && !cpu_gnt) return 1;
    return 2;
  endfunction

  // Advance one clock, observe the DUT, play the memory, drive requesters.
  task automatic tick();
    logic s;
    int   k;
    @(posedge clk);
    #1;
    cyc++;
    s = mem_read | mem_write;
    if (s) begin
      strobe_cycles++;
      if (!in_xfer) begin
        in_xfer     = 1;
        have_xfer   = 1;
        cur.start   = cyc;
        cur.len     = 0;
        cur.addr    = mem_addr;
        cur.wdata   = mem_wdata;
        cur.wr      = mem_write;
        cur.stable  = !(mem_read && mem_write);
        cur.owner   = gnt_owner();
        cur.act_cpu = cpu_ReadMem | cpu_WriteMem;
        cur.act_dma = dma_rd | dma_wr;
        cur.c_wr    = cpu_WriteMem;
        cur.c_addr  = cpu_Addressbus;
        cur.c_wdata = cpu_wdata;
        cur.d_wr    = dma_wr;
        cur.d_addr  = dma_addr;
        cur.d_wdata = dma_wdata;
        cur.waits   = rand_mode ? int'($urandom_range(0, 6)) : resp_waits;
      end else begin
        if (mem_addr !== cur.addr || mem_wdata !== cur.wdata || mem_write !== cur.wr ||
            (mem_read && mem_write) || gnt_owner() != cur.owner)
          cur.stable = 0;
      end
      cur.len++;
    end else begin
      in_xfer = 0;
    end
    if (cpu_MemDataready || dma_ready) begin
      if (!have_xfer) begin
        cur.len   = 0;
        cur.owner = 3;
        cur.start = cyc;
      end
      cur.done_c = cyc;
      cur.rdy    = {dma_ready, cpu_MemDataready};
      cur.terr   = timeout_err;
      cur.cpu_d  = cpu_Databus;
      cur.dma_d  = dma_rdata;
      recs.push_back(cur);
      have_xfer = 0;
    end
    if (s) begin
      mem_ready = ((cur.len - 1) == cur.waits);
      mem_rdata = rand_mode ? rmem[mem_addr[2:0]] : resp_rdata;
      if (rand_mode && mem_ready && mem_write) rmem[mem_addr[2:0]] = mem_wdata;
    end else begin
      mem_ready = idle_noise || (rand_mode && ($urandom_range(0, 3) == 0));
      mem_rdata = 16'($urandom);
    end
    if (cpu_MemDataready && cpu_auto) begin
      cpu_ReadMem = 0; cpu_WriteMem = 0; cpu_gap = $urandom_range(1, 3);
    end
    if (dma_ready && dma_auto) begin
      dma_rd = 0; dma_wr = 0; dma_gap = $urandom_range(1, 3);
    end
    if (gen_en) begin
      if (!(cpu_ReadMem | cpu_WriteMem)) begin
        if (cpu_gap > 0) cpu_gap--;
        else begin
          k = $urandom_range(0, 2);
          cpu_ReadMem = (k != 1); cpu_WriteMem = (k != 0);
          cpu_Addressbus = 16'($urandom); cpu_wdata = 16'($urandom);
        end
      end
      if (!(dma_rd | dma_wr)) begin
        if (dma_gap > 0) dma_gap--;
        else begin
          k = $urandom_range(0, 2);
          dma_rd = (k != 1); dma_wr = (k != 0);
          dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
        end
      end
    end
  endtask

  task automatic wait_rec(output xrec_t r, output bit ok);
    int n = 0;
    while (recs.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    ok = (recs.size() != 0);
    if (ok) r = recs.pop_front();
    else begin
      checks++;
      errors++;
      $display("FAIL wait_ready: no ready pulse within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  // Compare one transfer with what the requester asked for and what memory did.
  task automatic check_xfer(input string tag, input xrec_t r, input int eo, input logic ewr,
                            input logic [15:0] ea, input logic [15:0] ewd,
                            input logic [15:0] src, input logic eto);
    check({tag, " owner"}, r.owner, eo);
    check({tag, " ready_mask"}, 32'(r.rdy), (eo == 0) ? 1 : 2);
    check({tag, " write"}, 32'(r.wr), 32'(ewr));
    check({tag, " addr"}, 32'(r.addr), 32'(ea));
    if (ewr) check({tag, " wdata"}, 32'(r.wdata), 32'(ewd));
    check({tag, " stable"}, 32'(r.stable), 1);
    check({tag, " strobe_len"}, r.len, eto ? TMO : r.waits + 1);
    check({tag, " done_cycle"}, r.done_c, r.start + r.len);
    check({tag, " timeout_err"}, 32'(r.terr), 32'(eto));
    if (!ewr) begin
      if (eo == 0) exp_cpu_d = eto ? 16'hFFFF : src;
      else         exp_dma_d = eto ? 16'hFFFF : src;
    end
    check({tag, " cpu_data"}, 32'(r.cpu_d), 32'(exp_cpu_d));
    check({tag, " dma_data"}, 32'(r.dma_d), 32'(exp_dma_d));
    model_last_dma = (eo == 1);
  endtask

  // Transaction-level model: round-robin winner, shadow memory, abort rule.
  task automatic check_rand(input xrec_t r);
    int          eo;
    logic        ewr;
    logic [15:0] ea, ewd;
    logic        eto;
    if (r.act_cpu && r.act_dma) eo = model_last_dma ? 0 : 1;
    else if (r.act_cpu)         eo = 0;
    else                        eo = 1;
    ewr = (eo == 0) ? r.c_wr    : r.d_wr;
    ea  = (eo == 0) ? r.c_addr  : r.d_addr;
    ewd = (eo == 0) ? r.c_wdata : r.d_wdata;
    eto = (r.waits >= TMO);
    check_xfer($sformatf("rand%0d", nrand), r, eo, ewr, ea, ewd, ref_mem[ea[2:0]], eto);
    if (ewr && !eto) ref_mem[ea[2:0]] = ewd;
    nrand++;
  endtask

  vec_t  vecs[9];
  xrec_t r, r1, rs[4];
  bit    ok;
  int    issue;
  int    sc0;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 0,  16'hBEEF, 1, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h1234, 16'h00A5, 3,  16'h0000, 4, 1'b0, 16'hC0DE};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 99, 16'h1111, 4, 1'b1, 16'hFFFF};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2,  16'h1357, 3, 1'b0, 16'h1357};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0002, 16'h5AA5, 1,  16'h2222, 2, 1'b0, 16'hC0DE};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 4,  16'h3333, 4, 1'b1, 16'hFFFF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'h9876, 3,  16'h0000, 4, 1'b0, 16'h1357};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000, 0,  16'h2468, 1, 1'b0, 16'h2468};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0006, 16'h4321, 99, 16'h0000, 4, 1'b1, 16'h1357};

    ExternalReset_n = 0;
    cpu_ReadMem = 0; cpu_WriteMem = 0; cpu_Addressbus = 0; cpu_wdata = 0;
    dma_rd = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ExternalReset_n = 1;
    tick();

    // Reset values
    check("rst cpu_Databus", 32'(cpu_Databus), 0);
    check("rst dma_rdata", 32'(dma_rdata), 0);
    check("rst readies", 32'({cpu_MemDataready, dma_ready}), 0);
    check("rst strobes", 32'({mem_read, mem_write}), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_wdata", 32'(mem_wdata), 0);
    check("rst gnts", 32'({cpu_gnt, dma_gnt}), 0);
    check("rst timeout_err", 32'(timeout_err), 0);

    // Contention after reset: both reads held, CPU first then alternating.
    cpu_auto = 0; dma_auto = 0; resp_waits = 0; resp_rdata = 16'hC0DE;
    cpu_ReadMem = 1; cpu_Addressbus = 16'h0010;
    dma_rd = 1; dma_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      wait_rec(rs[i], ok);
      if (!ok) break;
      check_xfer($sformatf("cont%0d", i), rs[i], i % 2, 1'b0,
                 (i % 2 == 0) ? 16'h0010 : 16'h0020, 16'h0, 16'hC0DE, 1'b0);
      if (i > 0) check($sformatf("cont%0d spacing", i), rs[i].done_c - rs[i-1].done_c, 3);
    end
    cpu_ReadMem = 0; dma_rd = 0; cpu_auto = 1; dma_auto = 1;
    repeat (2) tick();

    // Directed single transfers from the table.
    for (int i = 0; i < 9; i++) begin
      resp_waits = vecs[i].waits;
      resp_rdata = vecs[i].rdata;
      tick();
      issue = cyc;
      if (vecs[i].dma) begin
        dma_rd = vecs[i].rd; dma_wr = vecs[i].wr;
        dma_addr = vecs[i].addr; dma_wdata = vecs[i].wdata;
      end else begin
        cpu_ReadMem = vecs[i].rd; cpu_WriteMem = vecs[i].wr;
        cpu_Addressbus = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      end
      wait_rec(r, ok);
      if (ok) begin
        check($sformatf("vec%0d start", i), r.start, issue + 1);
        check($sformatf("vec%0d len", i), r.len, vecs[i].exp_len);
        check($sformatf("vec%0d owner_data", i),
              32'(vecs[i].dma ? r.dma_d : r.cpu_d), 32'(vecs[i].exp_d));
        check_xfer($sformatf("vec%0d", i), r, vecs[i].dma ? 1 : 0, vecs[i].wr,
                   vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].waits >= TMO);
      end
      repeat (2) tick();
    end

    // Request held into the IDLE cycle after ready starts a second transfer.
    cpu_auto = 0; resp_waits = 0; resp_rdata = 16'h7777;
    tick();
    cpu_ReadMem = 1; cpu_Addressbus = 16'h0200;
    wait_rec(r1, ok);
    if (ok) begin
      check_xfer("held first", r1, 0, 1'b0, 16'h0200, 16'h0, 16'h7777, 1'b0);
      tick();
      tick();
      cpu_ReadMem = 0; cpu_auto = 1;
      wait_rec(r, ok);
      if (ok) begin
        check_xfer("held second", r, 0, 1'b0, 16'h0200, 16'h0, 16'h7777, 1'b0);
        check("held second start", r.start, r1.done_c + 2);
      end
    end
    repeat (2) tick();

    // mem_ready pulsed while idle must be ignored.
    sc0 = strobe_cycles;
    idle_noise = 1;
    repeat (4) tick();
    idle_noise = 0;
    repeat (2) tick();
    check("idle mem_ready strobes", strobe_cycles - sc0, 0);
    check("idle mem_ready responses", recs.size(), 0);

    // Reset during wait states of a CPU read; CPU must win the first tie after.
    resp_waits = 99;
    tick();
    cpu_ReadMem = 1; cpu_Addressbus = 16'h0100;
    tick();
    tick();
    check("rst_xfer pre strobe", 32'(mem_read), 1);
    #2 ExternalReset_n = 0;
    #1;
    check("rst_xfer strobes", 32'({mem_read, mem_write}), 0);
    check("rst_xfer gnts", 32'({cpu_gnt, dma_gnt}), 0);
    check("rst_xfer readies", 32'({cpu_MemDataready, dma_ready}), 0);
    check("rst_xfer cpu_Databus", 32'(cpu_Databus), 0);
    exp_cpu_d = 16'h0; exp_dma_d = 16'h0; model_last_dma = 1;
    cpu_Addressbus = 16'h0300; dma_rd = 1; dma_addr = 16'h0400;
    resp_waits = 0; resp_rdata = 16'hA1A1;
    repeat (2) tick();
    @(negedge clk);
    ExternalReset_n = 1;
    in_xfer = 0; have_xfer = 0; recs.delete();
    wait_rec(r, ok);
    if (ok) check_xfer("rst_xfer first", r, 0, 1'b0, 16'h0300, 16'h0, 16'hA1A1, 1'b0);
    wait_rec(r, ok);
    if (ok) check_xfer("rst_xfer second", r, 1, 1'b0, 16'h0400, 16'h0, 16'hA1A1, 1'b0);
    repeat (3) tick();

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 8; i++) begin
      rmem[i] = 16'($urandom);
      ref_mem[i] = rmem[i];
    end
    recs.delete();
    rand_mode = 1; gen_en = 1; cpu_gap = 0; dma_gap = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      while (recs.size() > 0) check_rand(recs.pop_front());
    end
    gen_en = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      while (recs.size() > 0) check_rand(recs.pop_front());
    end
    check("rand drained", 32'({cpu_ReadMem, cpu_WriteMem, dma_rd, dma_wr}), 0);
    check("rand enough transfers", 32'(nrand > 200), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single-ported system memory between the CPU memory port (ReadMem/WriteMem/Addressbus/Databus/MemDataready) and a DMA/IO master. It sits between the `cpu` top level and the memory model. It serialises transfers, alternates grants round-robin under contention, and returns data and a one-cycle ready pulse to the winning requester. A watchdog aborts transfers the memory never acknowledges.

## Interface
- AW, 16, address width
- DW, 16, data width
- TIMEOUT, 15, cycles in XFER without mem_ready before abort; 0 disables the watchdog
- clk  in  1  system clock, all state on rising edge
- ExternalReset_n  in  1  asynchronous, active-low reset
- cpu_ReadMem, cpu_WriteMem  in  1 each  CPU read/write request
- cpu_Addressbus  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_Databus  out  DW  read data returned to CPU
- cpu_MemDataready  out  1  CPU transfer-complete pulse
- dma_rd, dma_wr  in  1 each  DMA read/write request
- dma_addr  in  AW; dma_wdata  in  DW
- dma_rdata  out  DW; dma_ready  out  1  DMA transfer-complete pulse
- mem_read, mem_write  out  1 each  memory strobes
- mem_addr  out  AW; mem_wdata  out  DW
- mem_rdata  in  DW; mem_ready  in  1  memory acknowledge
- cpu_gnt, dma_gnt  out  1 each  current owner (status only)
- timeout_err  out  1  one-cycle abort pulse

## Operation
- **Reset values:** all outputs 0. State IDLE, last_grant = DMA (so the CPU wins the first tie), watchdog count 0.
- **FSM states:** IDLE, XFER, DONE.
- **IDLE:**
  - A requester is active when its rd or wr is high.
  - One active requester: grant it.
  - Both active: grant the one that is not last_grant.
  - On grant, register owner, address, write data and direction, update last_grant, then go to XFER.
  - If a requester asserts rd and wr together, the write wins.
- **XFER:**
  - mem_read or mem_write is held high, with mem_addr and mem_wdata stable from the latched values. Requester inputs are ignored.
  - The owner's gnt output is high.
  - The watchdog increments each cycle.
  - mem_ready sampled high: latch mem_rdata (reads only) and go to DONE.
  - Watchdog reaches TIMEOUT first: go to DONE with abort flagged.
- **DONE (exactly one cycle):**
  - Memory strobes are low.
  - The owner's ready output is high.
  - For reads, the owner's data output carries the latched mem_rdata. On abort it carries all-ones instead, and timeout_err is high.
  - Writes leave the data output unchanged.
  - Go to IDLE and clear the watchdog and gnt.
- **Data holding:** cpu_Databus and dma_rdata hold their last value until the next completed read for that requester.
- **Requester protocol:**
  - Hold address, data and request stable until ready is seen.
  - Deassert the request in the cycle immediately after the ready cycle. A request still high in that IDLE cycle is treated as a new transfer.
- **Reset mid-transfer:** strobes drop immediately (asynchronously). No ready pulse is produced and the transfer is lost.

## Timing
- Request high in cycle 0 (IDLE): XFER strobes are high in cycle 1.
- If mem_ready is high in cycle 1, DONE and ready occur in cycle 2. Minimum latency is 2 cycles, plus each extra memory wait cycle.
- Back-to-back: the earliest new grant is sampled in the IDLE cycle after DONE. Minimum transfer period is 3 cycles.
- **Contention:** with both requesters continuously active, grants alternate CPU, DMA, CPU, and so on. Neither requester waits more than one foreign transfer.
- **Abort:** with TIMEOUT=N and no mem_ready, strobes stay high for exactly N cycles and DONE follows.
- mem_ready outside XFER is ignored.
- **Watchdog:** the counter is $clog2(TIMEOUT+1) bits and saturates.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **CPU read, zero wait:** cpu_ReadMem with address 16'h0040, and memory returns 16'hBEEF with mem_ready in the first XFER cycle. Required: mem_read high for exactly 1 cycle with mem_addr 16'h0040, then cpu_MemDataready and cpu_Databus=16'hBEEF in cycle 2, with dma_ready low.
- **DMA write, 3 wait cycles:** dma_wr with address 16'h1234 and data 16'h00A5. Required: mem_write high for 4 cycles with stable mem_addr and mem_wdata, then one dma_ready pulse, and dma_rdata unchanged.
- **Contention after reset:** both CPU and DMA reads held. Required: grant order is CPU, DMA, CPU, DMA, with each ready pulse going to the granted requester only and 3-cycle spacing.
- **Timeout:** TIMEOUT=4 with mem_ready held low during a CPU read. Required: mem_read high for 4 cycles, then cpu_MemDataready, cpu_Databus=16'hFFFF and a timeout_err pulse; the next transfer proceeds normally.
- **Reset in XFER:** drive ExternalReset_n low during wait states. Required: strobes, gnt and ready are 0 immediately. After release with both requesters active, the CPU is granted first.
- **Protocol edges:** a requester asserting rd and wr together must produce a write. A request held one cycle past its ready must produce a second transfer. mem_ready pulsed while in IDLE must produce no response.
